// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory boot loader, the memory
// itself and the fetch-path testbenches.
//   MEM_BYTES / ADDR_W : instruction memory capacity and byte-address width
//   LEN_BYTES / CSUM_BYTES : framing overhead around the payload
//   ldr_state_t : loader FSM state encoding
package imem_pkg;

    localparam int unsigned MEM_BYTES  = 512;
    localparam int unsigned ADDR_W     = 9;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned LEN_BYTES  = 2;
    localparam int unsigned CSUM_BYTES = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN0  = 3'd1,
        ST_LEN1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_CSUM  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } ldr_state_t;

    // Total bytes on the wire for a frame carrying n payload bytes.
    function automatic int unsigned frame_bytes(input int unsigned n);
        return n + LEN_BYTES + CSUM_BYTES;
    endfunction

endpackage

// File: rtl/imem_loader_ctr.sv
// Down-counter used by the loader to track remaining payload bytes.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one
//   zero_c     : counter currently holds zero (decode of the register)
module imem_loader_ctr #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero_c
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/imem_loader.sv
// Boot-time writer for the byte-addressed instruction memory. Parses a
// LEN_HI, LEN_LO, payload, CSUM frame from a valid/ready byte stream, writes
// the payload from address 0 and releases the CPU only after the XOR
// checksum matches.
//   clk, rst             : clock, asynchronous active-high reset
//   start                : begin a load (ignored while busy)
//   in_valid/in_data     : stream byte, accepted when in_ready is high
//   in_ready             : loader expects a frame byte
//   mem_we/addr/wdata    : registered byte write port to instruction memory
//   busy, done, err      : load in progress / last load ok / last load failed
//   cpu_hold             : keeps the CPU in reset until a good image is loaded
module imem_loader #(
    parameter int unsigned ADDR_W    = imem_pkg::ADDR_W,
    parameter int unsigned MEM_BYTES = imem_pkg::MEM_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    import imem_pkg::*;

    ldr_state_t        state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        csum_q, csum_d;
    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [7:0]        mem_wdata_d;
    logic              ctr_load, ctr_dec, ctr_zero;
    logic [CNT_W-1:0]  ctr_val;
    logic [CNT_W-1:0]  len_w;
    logic              accept;

    assign in_ready = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                      (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign accept   = in_valid && in_ready;
    assign len_w    = {len_hi_q, in_data};
    assign cpu_hold = ~done;

    // Counter holds the payload bytes still to come after the current one,
    // so the zero flag marks the last payload byte.
    imem_loader_ctr #(.W(CNT_W)) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (ctr_load),
        .load_val (ctr_val),
        .dec      (ctr_dec),
        .zero_c   (ctr_zero)
    );

    // Next-state, datapath and write-port decode.
    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        addr_d      = addr_q;
        csum_d      = csum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        ctr_load    = 1'b0;
        ctr_val     = '0;
        ctr_dec     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_LEN0;
                    addr_d  = '0;
                    csum_d  = '0;
                end
            end
            ST_LEN0: begin
                if (accept) begin
                    len_hi_d = in_data;
                    state_d  = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (accept) begin
                    if (len_w > CNT_W'(MEM_BYTES)) begin
                        state_d = ST_ERROR;
                    end else if (len_w == '0) begin
                        state_d = ST_CSUM;
                    end else begin
                        ctr_load = 1'b1;
                        ctr_val  = len_w - CNT_W'(1);
                        state_d  = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = in_data;
                    csum_d      = csum_q ^ in_data;
                    // Address stops on the last byte so it never wraps.
                    if (ctr_zero) begin
                        state_d = ST_CSUM;
                    end else begin
                        ctr_dec = 1'b1;
                        addr_d  = addr_q + ADDR_W'(1);
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? ST_DONE : ST_ERROR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            len_hi_q  <= '0;
            addr_q    <= '0;
            csum_q    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_hi_q  <= len_hi_d;
            addr_q    <= addr_d;
            csum_q    <= csum_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            busy      <= (state_d == ST_LEN0) || (state_d == ST_LEN1) ||
                         (state_d == ST_DATA) || (state_d == ST_CSUM);
            done      <= (state_d == ST_DONE);
            err       <= (state_d == ST_ERROR);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected memory writes are queued by
// the stimulus side and popped by an independent write monitor; frame
// outcomes come from a frame-level reference model.
module tb_imem_loader;

    import imem_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic              cpu_hold;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cpu_hold  (cpu_hold)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    int         checks   = 0;
    int         failures = 0;
    wr_t        wq[$];
    wr_t        mon_e;
    logic [7:0] payload[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xsum();
        logic [7:0] x = 8'h00;
        foreach (payload[i]) x = x ^ payload[i];
        return x;
    endfunction

    // Write monitor: every mem_we pulse must match the oldest queued write.
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            if (wq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: addr=%0d data=%02h expected no write",
                         mem_addr, mem_wdata);
            end else begin
                mon_e = wq.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
                chk("wr_data", 32'(mem_wdata), 32'(mon_e.data));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge following the accept.
    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int g;
        int n;
        g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        repeat (g) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL byte_timeout: in_ready=%0b expected 1 within 50 cycles", in_ready);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_ready", 32'(in_ready), 32'd1);
        chk("start_done", 32'(done), 32'd0);
        chk("start_err", 32'(err), 32'd0);
        chk("start_hold", 32'(cpu_hold), 32'd1);
    endtask

    // Sends one frame built from the global payload queue.
    task automatic send_frame(input logic [15:0] len, input logic [7:0] cs,
                              input int gap, input bit poke);
        bit legal;
        bit exp_ok;
        legal  = (int'(len) <= int'(MEM_BYTES));
        exp_ok = legal && (cs == xsum());
        pulse_start();
        send_byte(len[15:8], gap);
        if (poke) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("poke_busy", 32'(busy), 32'd1);
            chk("poke_ready", 32'(in_ready), 32'd1);
        end
        send_byte(len[7:0], gap);
        if (!legal) begin
            chk("oversize_err", 32'(err), 32'd1);
            chk("oversize_ready", 32'(in_ready), 32'd0);
            chk("oversize_busy", 32'(busy), 32'd0);
            chk("oversize_hold", 32'(cpu_hold), 32'd1);
            repeat (3) @(negedge clk);
            return;
        end
        for (int i = 0; i < int'(len); i++) begin
            wq.push_back('{addr: ADDR_W'(i), data: payload[i]});
            send_byte(payload[i], gap);
        end
        send_byte(cs, gap);
        chk("res_done", 32'(done), 32'(exp_ok));
        chk("res_err", 32'(err), 32'(!exp_ok));
        chk("res_hold", 32'(cpu_hold), 32'(!exp_ok));
        chk("res_busy", 32'(busy), 32'd0);
        chk("res_ready", 32'(in_ready), 32'd0);
        chk("res_writes_drained", 32'(wq.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
    endtask

    initial begin
        logic [15:0] rl;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Nominal 8-byte image with correct checksum, then with CSUM 00.
        payload = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        send_frame(16'd8, xsum(), 0, 1'b0);
        send_frame(16'd8, 8'h00, 0, 1'b0);

        // Oversize length, then zero-length frames.
        payload = {};
        send_frame(16'd513, 8'h00, 0, 1'b0);
        send_frame(16'd0, 8'h00, 0, 1'b0);
        send_frame(16'd0, 8'h01, 0, 1'b0);

        // Full-capacity image with random input bubbles.
        payload = {};
        for (int i = 0; i < int'(MEM_BYTES); i++) payload.push_back(8'($urandom));
        send_frame(16'(MEM_BYTES), xsum(), 3, 1'b0);

        // Reset after three payload bytes of a 4-byte frame.
        payload = '{8'hA5, 8'h3C, 8'h7E, 8'h01};
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        for (int i = 0; i < 3; i++) begin
            wq.push_back('{addr: ADDR_W'(i), data: payload[i]});
            send_byte(payload[i], 0);
        end
        #2 rst = 1'b1;
        #1 chk_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_writes_drained", 32'(wq.size()), 32'd0);
        // Restart with a full frame, pulsing start mid-frame.
        send_frame(16'd4, xsum(), 1, 1'b1);

        // Random frames: mixed lengths, checksums and an occasional oversize.
        for (int f = 0; f < 8; f++) begin
            payload = {};
            if ($urandom_range(0, 5) == 0) begin
                rl = 16'($urandom_range(int'(MEM_BYTES) + 1, 65535));
            end else begin
                rl = 16'($urandom_range(0, 24));
                for (int i = 0; i < int'(rl); i++) payload.push_back(8'($urandom));
            end
            send_frame(rl, ($urandom_range(0, 1) == 1) ? xsum() : 8'($urandom),
                       int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        chk("final_writes_drained", 32'(wq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
